cache_axi_arbiter: RTL and testbench
====================================

Name: cache_axi_arbiter

Overview:
Parametrised successor to the single-line cache-to-memory bus. Arbitrates up to CONNECTIONS cache clients onto one AXI4 master port using round-robin. Performs full-line burst reads (fills) and burst writes (writebacks) with correct W-channel data/last generation and B-channel completion. Returns per-client completion with error status. Sits between the L1 I/D caches and the top-level AXI interconnect.

Parameters:
DATA_WIDTH, 64, AXI data beat width in bits (power of 2, >=8)
ADDR_WIDTH, 64, address width
BEATS, 8, beats per cache line (power of 2, 1..256)
CONNECTIONS, 2, number of cache clients (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  CONNECTIONS  client request pending
req_store  in  CONNECTIONS  1=writeback, 0=fill
req_addr  in  CONNECTIONS x ADDR_WIDTH  line address (low offset bits ignored)
req_wdata  in  CONNECTIONS x DATA_WIDTH*BEATS  writeback line, beat 0 in LSBs
req_ready  out  CONNECTIONS  one-hot accept pulse
resp_valid  out  CONNECTIONS  one-hot completion
resp_ready  in  CONNECTIONS  client takes completion
resp_rdata  out  DATA_WIDTH*BEATS  fill line, shared by all clients
resp_err  out  1  any non-OKAY response or beat-count mismatch in this transaction
m_axi_ar{addr,len,size,burst,valid} out / m_axi_arready in
m_axi_r{data,resp,last,valid} in / m_axi_rready out
m_axi_aw{addr,len,size,burst,valid} out / m_axi_awready in
m_axi_w{data,last,valid} out / m_axi_wready in
m_axi_b{resp,valid} in / m_axi_bready out

Behaviour:
- Reset (async, immediate): state IDLE, rr_last=CONNECTIONS-1, beat counter 0, line buffer 0, err 0; all valid/ready outputs 0. Reset mid-burst abandons the transaction; no AXI cleanup.
- Constants: ar/awlen=BEATS-1, ar/awsize=log2(DATA_WIDTH/8), ar/awburst=2'b01 (INCR); ar/awaddr = latched addr with low log2(BEATS*DATA_WIDTH/8) bits zeroed.
- Arbitration in IDLE: winner = first asserted req_valid scanning rr_last+1, rr_last+2, ... modulo CONNECTIONS. On winner: req_ready[winner]=1 for that one cycle (combinational in IDLE), latch addr, store flag, wdata (if store); rr_last<=winner; next state AR or AW. No request -> stay IDLE, req_ready=0.
- AR: arvalid=1 until arready; -> R.
- R: rready=1. Each rvalid beat written to buffer[cnt], cnt++. rresp!=0 sets err. rlast -> RESP. rlast with cnt!=BEATS-1 sets err. Beats arriving with cnt already BEATS are discarded, err set.
- AW: awvalid=1 until awready; -> W with cnt=0.
- W: wvalid=1, wdata=buffer[cnt], wlast=(cnt==BEATS-1). On wready: cnt++; if wlast -> B. wvalid never drops mid-burst.
- B: bready=1; on bvalid, bresp!=0 sets err; -> RESP.
- RESP: resp_valid[granted]=1, resp_rdata=buffer (don't-care for stores), resp_err=err; held until resp_ready[granted]; -> IDLE, cnt=0, err=0. One transaction outstanding at a time; first new grant no earlier than the cycle after RESP exit.
- req_valid deassertion by a non-granted client is legal anytime; the granted client must hold req_* stable only until req_ready.
- Simultaneous requests: round-robin guarantees no client waits more than CONNECTIONS-1 transactions.

Test Plan:
- Single fill: client0 addr 0x1038 -> araddr=0x1000, arlen=7, arsize=3, arburst=01; 8 beats 0x0..0x7 -> resp_valid=01, resp_rdata beat i = i, resp_err=0.
- Writeback: client1 store, wdata beats 0xA0..0xA7, wready toggled every other cycle -> wdata sequence exact, wlast only on 8th beat, bready then resp_valid=10.
- Fairness: both clients hold req_valid for 4 transactions -> grants 0,1,0,1.
- Errors: rresp=2'b10 on beat 3 -> resp_err=1; early rlast on beat 5 -> resp_err=1; next clean transaction resp_err=0.
- Backpressure: resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, no new req_ready.
- Reset asserted mid-R burst (beat 4) -> all outputs 0 same cycle; after release client0 granted first.

Source files
------------

// File: rtl/cache_axi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_axi_arbiter : round-robin arbiter of cache line fills/writebacks onto
//                     one AXI4 master port.   Revision 1.0
// ---------------------------------------------------------------------------
module cache_axi_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 64,
  parameter int BEATS       = 8,
  parameter int CONNECTIONS = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [CONNECTIONS-1:0]                      req_valid,
  input  logic [CONNECTIONS-1:0]                      req_store,
  input  logic [CONNECTIONS-1:0][ADDR_WIDTH-1:0]      req_addr,
  input  logic [CONNECTIONS-1:0][DATA_WIDTH*BEATS-1:0] req_wdata,
  output logic [CONNECTIONS-1:0]                      req_ready,
  output logic [CONNECTIONS-1:0]                      resp_valid,
  input  logic [CONNECTIONS-1:0]                      resp_ready,
  output logic [DATA_WIDTH*BEATS-1:0]                 resp_rdata,
  output logic                                        resp_err,
  output logic [ADDR_WIDTH-1:0]                       m_axi_araddr,
  output logic [7:0]                                  m_axi_arlen,
  output logic [2:0]                                  m_axi_arsize,
  output logic [1:0]                                  m_axi_arburst,
  output logic                                        m_axi_arvalid,
  input  logic                                        m_axi_arready,
  input  logic [DATA_WIDTH-1:0]                       m_axi_rdata,
  input  logic [1:0]                                  m_axi_rresp,
  input  logic                                        m_axi_rlast,
  input  logic                                        m_axi_rvalid,
  output logic                                        m_axi_rready,
  output logic [ADDR_WIDTH-1:0]                       m_axi_awaddr,
  output logic [7:0]                                  m_axi_awlen,
  output logic [2:0]                                  m_axi_awsize,
  output logic [1:0]                                  m_axi_awburst,
  output logic                                        m_axi_awvalid,
  input  logic                                        m_axi_awready,
  output logic [DATA_WIDTH-1:0]                       m_axi_wdata,
  output logic                                        m_axi_wlast,
  output logic                                        m_axi_wvalid,
  input  logic                                        m_axi_wready,
  input  logic [1:0]                                  m_axi_bresp,
  input  logic                                        m_axi_bvalid,
  output logic                                        m_axi_bready
);

  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GNT_W = $clog2(CONNECTIONS);
  localparam int OFF_W = $clog2(BEATS * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_RESP = 3'd6
  } state_t;

  state_t                              r_state;
  logic [GNT_W-1:0]                    r_rr_last;
  logic [GNT_W-1:0]                    r_gnt;
  logic [CNT_W-1:0]                    r_cnt;
  logic [BEATS-1:0][DATA_WIDTH-1:0]    r_buf;
  logic                                r_err;
  logic [ADDR_WIDTH-1:0]               r_addr;
  logic                                r_arvalid;
  logic                                r_rready;
  logic                                r_awvalid;
  logic                                r_wvalid;
  logic                                r_bready;
  logic [CONNECTIONS-1:0]              r_resp_valid;

  logic                                w_found;
  logic [GNT_W-1:0]                    w_winner;
  logic [GNT_W-1:0]                    w_cand;
  logic [CONNECTIONS-1:0]              w_req_ready;
  logic [CONNECTIONS-1:0]              w_gnt_oh;
  logic [IDX_W-1:0]                    w_idx;
  logic                                w_last_beat;

  // Scan starts one past the last winner so every client gets a turn.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int i = 1; i <= CONNECTIONS; i++) begin
      w_cand = GNT_W'((int'(r_rr_last) + i) % CONNECTIONS);
      if (!w_found && req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_req_ready = '0;
    if (r_state == S_IDLE && w_found && !reset)
      w_req_ready[w_winner] = 1'b1;
  end

  always_comb begin
    w_gnt_oh        = '0;
    w_gnt_oh[r_gnt] = 1'b1;
  end

  assign w_idx       = r_cnt[IDX_W-1:0];
  assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));

  assign req_ready     = w_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_buf;
  assign resp_err      = r_err && (r_state == S_RESP);

  assign m_axi_araddr  = r_addr & ADDR_MASK;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign m_axi_awaddr  = r_addr & ADDR_MASK;
  assign m_axi_awlen   = 8'(BEATS - 1);
  assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_buf[w_idx];
  assign m_axi_wlast   = r_wvalid && w_last_beat;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rr_last    <= GNT_W'(CONNECTIONS - 1);
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_buf        <= '0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_resp_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt     <= w_winner;
            r_rr_last <= w_winner;
            r_addr    <= req_addr[w_winner];
            r_cnt     <= '0;
            r_err     <= 1'b0;
            if (req_store[w_winner]) begin
              r_buf     <= req_wdata[w_winner];
              r_awvalid <= 1'b1;
              r_state   <= S_AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            // Surplus beats past a full line are dropped but flagged.
            if (r_cnt < CNT_W'(BEATS)) begin
              r_buf[w_idx] <= m_axi_rdata;
              r_cnt        <= r_cnt + CNT_W'(1);
            end else begin
              r_err <= 1'b1;
            end
            if (m_axi_rresp != 2'b00)
              r_err <= 1'b1;
            if (m_axi_rlast) begin
              if (!w_last_beat)
                r_err <= 1'b1;
              r_rready     <= 1'b0;
              r_resp_valid <= w_gnt_oh;
              r_state      <= S_RESP;
            end
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (m_axi_wready) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last_beat) begin
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_B;
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00)
              r_err <= 1'b1;
            r_bready     <= 1'b0;
            r_resp_valid <= w_gnt_oh;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready[r_gnt]) begin
            r_resp_valid <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cache_axi_arbiter : directed self-checking bench for cache_axi_arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cache_axi_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int NB = 8;
  localparam int NC = 2;
  localparam int LW = DW * NB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC-1:0]         req_valid, req_store, req_ready, resp_valid, resp_ready;
  logic [NC-1:0][AW-1:0] req_addr;
  logic [NC-1:0][LW-1:0] req_wdata;
  logic [LW-1:0]         resp_rdata;
  logic                  resp_err;
  logic [AW-1:0]         araddr, awaddr;
  logic [7:0]            arlen, awlen;
  logic [2:0]            arsize, awsize;
  logic [1:0]            arburst, awburst, rresp, bresp;
  logic                  arvalid, arready, rlast, rvalid, rready;
  logic                  awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]         rdata, wdata;

  int n_checks = 0;
  int n_fail   = 0;

  cache_axi_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEATS(NB), .CONNECTIONS(NC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [DW-1:0] base);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < NB; i++) l[i*DW +: DW] = base + DW'(i);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [0:0] c, input logic st, input logic [AW-1:0] a,
                         input logic [LW-1:0] wl);
    logic [NC-1:0] oh;
    oh = NC'(1) << c;
    req_store[c] = st;
    req_addr[c]  = a;
    req_wdata[c] = wl;
    req_valid[c] = 1'b1;
    #1;
    for (int t = 0; t < 30 && req_ready !== oh; t++) tick();
    check_eq("grant", req_ready, oh);
    tick();
    req_valid[c] = 1'b0;
  endtask

  task automatic serve_read(input logic [AW-1:0] exp_addr, input logic [DW-1:0] base,
                            input int nbeats, input int err_beat);
    for (int t = 0; t < 30 && arvalid !== 1'b1; t++) tick();
    check_eq("arvalid", arvalid, 1'b1);
    check_eq("araddr", araddr, exp_addr);
    check_eq("ar_len_size_burst", {arlen, arsize, arburst}, {8'd7, 3'd3, 2'b01});
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("rready", rready, 1'b1);
    for (int i = 0; i < nbeats; i++) begin
      rvalid = 1'b1;
      rdata  = base + DW'(i);
      rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      rlast  = (i == nbeats - 1);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic serve_write(input logic [AW-1:0] exp_addr, input logic [LW-1:0] line,
                             input logic toggle);
    int k;
    for (int t = 0; t < 30 && awvalid !== 1'b1; t++) tick();
    check_eq("awvalid", awvalid, 1'b1);
    check_eq("awaddr", awaddr, exp_addr);
    check_eq("aw_len_size_burst", {awlen, awsize, awburst}, {8'd7, 3'd3, 2'b01});
    awready = 1'b1;
    tick();
    awready = 1'b0;
    k = 0;
    for (int t = 0; t < 60 && k < NB; t++) begin
      wready = toggle ? (t % 2 == 1) : 1'b1;
      check_eq("wvalid", wvalid, 1'b1);
      if (wready) begin
        check_eq("wdata", wdata, line[k*DW +: DW]);
        check_eq("wlast", wlast, k == NB - 1);
        k++;
      end
      tick();
    end
    wready = 1'b0;
    check_eq("wbeats", k, NB);
    check_eq("wvalid_done", wvalid, 1'b0);
    check_eq("bready", bready, 1'b1);
    bvalid = 1'b1;
    bresp  = 2'b00;
    tick();
    bvalid = 1'b0;
  endtask

  task automatic take_resp(input logic [0:0] c, input logic [LW-1:0] exp_line,
                           input logic chk_data, input logic exp_err, input int hold);
    logic [NC-1:0] oh;
    logic [LW-1:0] held;
    oh = NC'(1) << c;
    for (int t = 0; t < 30 && resp_valid === '0; t++) tick();
    check_eq("resp_valid", resp_valid, oh);
    check_eq("resp_err", resp_err, exp_err);
    if (chk_data) check_eq("resp_rdata", resp_rdata, exp_line);
    held = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("bp_valid", resp_valid, oh);
      check_eq("bp_rdata", resp_rdata, held);
      check_eq("bp_no_grant", req_ready, '0);
    end
    resp_ready[c] = 1'b1;
    tick();
    resp_ready[c] = 1'b0;
    check_eq("resp_done", resp_valid, '0);
  endtask

  initial begin
    logic [NC-1:0] oh;
    reset = 1'b1;
    req_valid = '0; req_store = '0; req_addr = '0; req_wdata = '0; resp_ready = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    repeat (3) tick();
    check_eq("reset_outs", {req_ready, resp_valid, arvalid, rready, awvalid, wvalid, bready},
             '0);
    reset = 1'b0;
    tick();
    check_eq("idle_no_grant", req_ready, '0);

    // Single fill, unaligned address.
    request(1'b0, 1'b0, 64'h1038, '0);
    serve_read(64'h1000, 64'h0, 8, -1);
    take_resp(1'b0, mk_line(64'h0), 1'b1, 1'b0, 0);

    // Writeback with throttled W channel.
    request(1'b1, 1'b1, 64'h207F, mk_line(64'hA0));
    serve_write(64'h2040, mk_line(64'hA0), 1'b1);
    take_resp(1'b1, '0, 1'b0, 1'b0, 0);

    // Both clients hold requests: grants must alternate starting at 0.
    req_store = '0;
    req_addr[0] = 64'h3000;
    req_addr[1] = 64'h4000;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      for (int t = 0; t < 30 && req_ready === '0; t++) tick();
      check_eq("rr_grant", req_ready, oh);
      tick();
      if (k == 3) req_valid = '0;
      serve_read((k % 2 == 0) ? 64'h3000 : 64'h4000, DW'(64'h100 * k), 8, -1);
      take_resp((k % 2 == 0) ? 1'b0 : 1'b1, mk_line(DW'(64'h100 * k)), 1'b1, 1'b0, 0);
    end

    // Error cases, then a clean transaction clears the flag.
    request(1'b0, 1'b0, 64'h5000, '0);
    serve_read(64'h5000, 64'h10, 8, 3);
    take_resp(1'b0, mk_line(64'h10), 1'b1, 1'b1, 0);
    request(1'b0, 1'b0, 64'h5040, '0);
    serve_read(64'h5040, 64'h20, 6, -1);
    take_resp(1'b0, '0, 1'b0, 1'b1, 0);
    request(1'b0, 1'b0, 64'h5080, '0);
    serve_read(64'h5080, 64'h30, 8, -1);
    take_resp(1'b0, mk_line(64'h30), 1'b1, 1'b0, 0);

    // Completion backpressure while another client waits.
    request(1'b1, 1'b0, 64'h6000, '0);
    serve_read(64'h6000, 64'h40, 8, -1);
    req_store[0] = 1'b0;
    req_addr[0]  = 64'h7000;
    req_valid[0] = 1'b1;
    take_resp(1'b1, mk_line(64'h40), 1'b1, 1'b0, 5);
    request(1'b0, 1'b0, 64'h7000, '0);
    serve_read(64'h7000, 64'h50, 8, -1);
    take_resp(1'b0, mk_line(64'h50), 1'b1, 1'b0, 0);

    // Reset in the middle of a read burst.
    request(1'b1, 1'b0, 64'h8000, '0);
    for (int t = 0; t < 30 && arvalid !== 1'b1; t++) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1;
      rdata  = DW'(64'h60 + i);
      tick();
    end
    rdata = DW'(64'h64);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_outs", {req_ready, resp_valid, arvalid, rready, awvalid, wvalid, bready, wlast},
             '0);
    check_eq("rst_rdata", resp_rdata, '0);
    rvalid = 1'b0;
    req_store = '0;
    req_addr[0] = 64'h9000;
    req_addr[1] = 64'hA000;
    req_valid = 2'b11;
    #1;
    check_eq("rst_no_grant", req_ready, '0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_grant", req_ready, 2'b01);
    tick();
    req_valid = '0;
    serve_read(64'h9000, 64'h70, 8, -1);
    take_resp(1'b0, mk_line(64'h70), 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
